bounce_counter_cfg: RTL



---
 rtl/bounce_counter_cfg_if.sv | 31 +++
 rtl/bounce_counter_cfg.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bounce_counter_cfg_if.sv
// Control/status bundle for bounce_counter_cfg: configuration and strobes in,
// registered count and status out.
interface bounce_counter_cfg_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  // No handshake: load and enb are sampled every rising edge (load wins over
  // enb), and every status output is registered and valid one cycle later.
  logic              enb;
  logic              load;
  logic [WIDTH-1:0]  data_in;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  lo_bound;
  logic [WIDTH-1:0]  hi_bound;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  count;
  logic              dir_up;
  logic              tc;
  logic              done;
  logic              cfg_err;

  modport master (
    output enb, load, data_in, mode, lo_bound, hi_bound, step,
    input  count, dir_up, tc, done, cfg_err
  );

  modport slave (
    input  enb, load, data_in, mode, lo_bound, hi_bound, step,
    output count, dir_up, tc, done, cfg_err
  );
endinterface

// File: rtl/bounce_counter_cfg.sv
// Multi-mode bounded counter (wrap up, wrap down, bounce, one-shot) with
// programmable step and registered terminal-count and status outputs.
module bounce_counter_cfg #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic                  clk,
  input  logic                  asyn_rstn,
  bounce_counter_cfg_if.slave   bus
);
  localparam int XW = WIDTH + 1;

  typedef enum logic [1:0] {
    UP_WRAP   = 2'b00,
    DOWN_WRAP = 2'b01,
    BOUNCE    = 2'b10,
    ONE_SHOT  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_count;
  logic             r_dir_up;
  logic             r_tc;
  logic             r_done;
  logic             r_cfg_err;

  mode_e            w_mode;
  logic [XW-1:0]    w_s;
  logic [XW-1:0]    w_cnt;
  logic [XW-1:0]    w_lo;
  logic [XW-1:0]    w_hi;
  logic [XW-1:0]    w_up;
  logic [XW-1:0]    w_lo_s;
  logic [WIDTH-1:0] w_dn;
  logic             w_cfg_err;
  logic             w_oor;
  logic             w_oor_to_hi;

  // All comparisons use one extra bit so count+step can never wrap silently.
  assign w_mode      = mode_e'(bus.mode);
  assign w_s         = (bus.step == '0) ? XW'(1) : XW'(bus.step);
  assign w_cnt       = XW'(r_count);
  assign w_lo        = XW'(bus.lo_bound);
  assign w_hi        = XW'(bus.hi_bound);
  assign w_up        = w_cnt + w_s;
  assign w_lo_s      = w_lo + w_s;
  assign w_dn        = r_count - w_s[WIDTH-1:0];
  assign w_cfg_err   = (bus.lo_bound > bus.hi_bound);
  assign w_oor       = (w_cnt < w_lo) || (w_cnt > w_hi);
  assign w_oor_to_hi = (w_mode == DOWN_WRAP) || ((w_mode == BOUNCE) && !r_dir_up);

  always_ff @(posedge clk) begin
    if (!asyn_rstn) begin
      r_count   <= '0;
      r_dir_up  <= 1'b1;
      r_tc      <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_err;
      r_tc      <= 1'b0;
      if (bus.load) begin
        r_count <= bus.data_in;
        r_done  <= 1'b0;
      end else if (bus.enb && !w_cfg_err) begin
        if (w_oor) begin
          // Re-enter the window at the end the current direction starts from.
          r_count <= w_oor_to_hi ? bus.hi_bound : bus.lo_bound;
          if (w_mode == DOWN_WRAP)
            r_dir_up <= 1'b0;
          else if (w_mode != BOUNCE)
            r_dir_up <= 1'b1;
        end else begin
          case (w_mode)
            UP_WRAP: begin
              r_dir_up <= 1'b1;
              if (w_up > w_hi) begin
                r_count <= bus.lo_bound;
                r_tc    <= 1'b1;
              end else begin
                r_count <= w_up[WIDTH-1:0];
              end
            end
            DOWN_WRAP: begin
              r_dir_up <= 1'b0;
              if (w_cnt < w_lo_s) begin
                r_count <= bus.hi_bound;
                r_tc    <= 1'b1;
              end else begin
                r_count <= w_dn;
              end
            end
            BOUNCE: begin
              if (r_dir_up) begin
                if (w_up >= w_hi) begin
                  r_count  <= bus.hi_bound;
                  r_dir_up <= 1'b0;
                  r_tc     <= 1'b1;
                end else begin
                  r_count <= w_up[WIDTH-1:0];
                end
              end else begin
                if (w_cnt <= w_lo_s) begin
                  r_count  <= bus.lo_bound;
                  r_dir_up <= 1'b1;
                  r_tc     <= 1'b1;
                end else begin
                  r_count <= w_dn;
                end
              end
            end
            default: begin
              r_dir_up <= 1'b1;
              if (!r_done) begin
                if (w_up >= w_hi) begin
                  r_count <= bus.hi_bound;
                  r_done  <= 1'b1;
                  r_tc    <= 1'b1;
                end else begin
                  r_count <= w_up[WIDTH-1:0];
                end
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.dir_up  = r_dir_up;
  assign bus.tc      = r_tc;
  assign bus.done    = r_done;
  assign bus.cfg_err = r_cfg_err;
endmodule
